// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core and its job master: datapath width,
// master state encoding and the core's operand load timing.
package gcd_pkg;

  localparam int GCD_DATA_W = 8;

  // Cycles after the start edge at which the core loads A and B from data_input.
  localparam int START_TO_A = 1;
  localparam int START_TO_B = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } master_state_e;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Done-timeout counter: synchronous clear, count enable, terminal count at TIMEOUT-1.
module gcd_timeout_ctr #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = $clog2(TIMEOUT+1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT-1));

endmodule

// File: rtl/gcd_job_master.sv
// Initiator for the GCD core: takes operand pairs, feeds A then B over the
// shared data bus, waits for done (with timeout) and returns the result.
module gcd_job_master
  import gcd_pkg::*;
#(
  parameter int DATA_W  = GCD_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_gcd,
  output logic              out_err,
  output logic              gcd_start,
  output logic [DATA_W-1:0] gcd_data,
  input  logic              gcd_done,
  input  logic [DATA_W-1:0] gcd_result
);

  localparam int CNT_W = $clog2(TIMEOUT+1);

  master_state_e     state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] out_gcd_q, out_gcd_d, gcd_data_q, gcd_data_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic              out_err_q, out_err_d, gcd_start_q, gcd_start_d;
  logic              ctr_clr, ctr_en, ctr_tc;

  gcd_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .tc      (ctr_tc)
  );

  // Outputs are registered, so each one is computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    out_gcd_d   = out_gcd_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    gcd_data_d  = gcd_data_q;
    gcd_start_d = 1'b0;
    in_ready_d  = 1'b0;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d = in_a;
          b_d = in_b;
          // The subtractive core never terminates on a zero operand.
          if (in_a == '0 || in_b == '0) begin
            out_gcd_d   = in_a | in_b;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            gcd_start_d = 1'b1;
            gcd_data_d  = in_a;
            state_d     = S_START;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_START: begin
        gcd_data_d = a_q;
        state_d    = S_LOAD_A;
      end
      S_LOAD_A: begin
        gcd_data_d = b_q;
        state_d    = S_LOAD_B;
      end
      S_LOAD_B: begin
        ctr_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gcd_done) begin
          out_gcd_d   = gcd_result;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (ctr_tc) begin
          out_gcd_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          ctr_en = 1'b1;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_gcd_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      gcd_data_q  <= '0;
      gcd_start_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_gcd_q   <= out_gcd_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      gcd_data_q  <= gcd_data_d;
      gcd_start_q <= gcd_start_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_gcd   = out_gcd_q;
  assign out_err   = out_err_q;
  assign gcd_start = gcd_start_q;
  assign gcd_data  = gcd_data_q;

endmodule

// File: tb/tb_gcd_job_master.sv
// Directed bench for gcd_job_master with a small subtractive GCD core model.
module tb_gcd_job_master;

  localparam int DW = 8;
  localparam int TMO = 16;

  logic          i_clk = 1'b0, i_rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          in_ready, out_valid, out_err, gcd_start, gcd_done;
  logic [DW-1:0] out_gcd, gcd_data, gcd_result;

  int n_tests = 0, n_fail = 0, starts = 0, s0, n;
  logic core_dead = 1'b0;

  gcd_job_master #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .gcd_start(gcd_start), .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  always #5 i_clk = ~i_clk;

  // Core model: start at edge N, A at N+1, B at N+2, then one subtraction per cycle.
  logic [1:0]    cst;
  logic [DW-1:0] ra, rb;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cst <= 2'd0; ra <= '0; rb <= '0; gcd_done <= 1'b0;
    end else begin
      case (cst)
        2'd0: if (gcd_start) begin cst <= 2'd1; gcd_done <= 1'b0; end
        2'd1: begin ra <= gcd_data; cst <= 2'd2; end
        2'd2: begin rb <= gcd_data; cst <= 2'd3; end
        default: begin
          if (ra == rb) begin cst <= 2'd0; gcd_done <= !core_dead; end
          else if (ra > rb) ra <= ra - rb;
          else rb <= rb - ra;
        end
      endcase
    end
  end
  assign gcd_result = ra;

  always @(negedge i_clk) if (gcd_start) starts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (out_valid) break;
      chk({tag, "_busy_in_ready"}, in_ready, 0);
    end
    chk({tag, "_valid"}, out_valid, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gcd_start", gcd_start, 0);
    chk("rst_gcd_data", gcd_data, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_err", out_err, 0);
    i_rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // (48,18) through the core
    s0 = starts;
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    tick();
    in_valid = 1'b0;
    chk("j1_start", gcd_start, 1);
    chk("j1_data_start", gcd_data, 48);
    chk("j1_in_ready", in_ready, 0);
    tick();
    chk("j1_start_lo", gcd_start, 0);
    chk("j1_data_a", gcd_data, 48);
    tick();
    chk("j1_data_b", gcd_data, 18);
    wait_valid("j1", 40);
    chk("j1_gcd", out_gcd, 6);
    chk("j1_err", out_err, 0);
    chk("j1_one_start", starts - s0, 1);
    out_ready = 1'b1;
    tick();
    chk("j1_valid_drop", out_valid, 0);
    chk("j1_in_ready_back", in_ready, 1);

    // Zero short-circuits, out_ready held high
    s0 = starts;
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd35;
    tick();
    in_valid = 1'b0;
    chk("z1_valid_1cyc", out_valid, 1);
    chk("z1_gcd", out_gcd, 35);
    chk("z1_err", out_err, 0);
    tick();
    chk("z1_valid_drop", out_valid, 0);
    chk("z1_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd0;
    tick();
    in_valid = 1'b0;
    chk("z2_valid_1cyc", out_valid, 1);
    chk("z2_gcd", out_gcd, 0);
    tick();
    chk("z_no_start", starts - s0, 0);

    // Timeout: core never raises done
    core_dead = 1'b1;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t_data_b", gcd_data, 3);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) break;
      n++;
    end
    chk("t_wait_cycles", n, TMO);
    chk("t_err", out_err, 1);
    chk("t_gcd", out_gcd, 0);
    tick();
    core_dead = 1'b0;

    // (21,14) with back-pressure; a second pair waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd21; in_b = 8'd14;
    tick();
    chk("bp_start", gcd_start, 1);
    in_a = 8'd8; in_b = 8'd12;
    wait_valid("bp", 40);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_gcd", out_gcd, 7);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_in_ready", in_ready, 1);
    tick();
    chk("bp2_start", gcd_start, 1);
    chk("bp2_data", gcd_data, 8);
    in_valid = 1'b0;
    wait_valid("bp2", 40);
    chk("bp2_gcd", out_gcd, 4);
    tick();

    // Back-to-back with in_valid held
    in_valid = 1'b1; in_a = 8'd17; in_b = 8'd5;
    tick();
    chk("bb1_start", gcd_start, 1);
    in_a = 8'd100; in_b = 8'd75;
    wait_valid("bb1", 40);
    chk("bb1_gcd", out_gcd, 1);
    tick();
    chk("bb1_in_ready", in_ready, 1);
    tick();
    chk("bb2_start", gcd_start, 1);
    chk("bb2_data", gcd_data, 100);
    in_valid = 1'b0;
    wait_valid("bb2", 40);
    chk("bb2_gcd", out_gcd, 25);
    tick();

    // Reset during WAIT, then (9,6)
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #1 i_rst_n = 1'b0;
    #1;
    chk("mr_gcd_start", gcd_start, 0);
    chk("mr_gcd_data", gcd_data, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_out_gcd", out_gcd, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("mr_in_ready_back", in_ready, 1);
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd6;
    tick();
    in_valid = 1'b0;
    wait_valid("mr", 40);
    chk("mr_gcd", out_gcd, 3);
    chk("mr_err", out_err, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_job_master.md
Name: gcd_job_master

Overview:
- Initiator side of the GCD core's start/data/done interface.
- Accepts operand pairs over a valid/ready input channel and sequences them serially onto the GCD core's shared data_input bus (A, then B).
- Waits for the core's done, captures the result, and returns it over a valid/ready output channel.
- Short-circuits zero operands, which the subtractive core cannot terminate on, and enforces a done timeout.

Parameters:
- DATA_W, 8, operand/result width; matches the GCD datapath width.
- TIMEOUT, 1024, maximum cycles to wait for gcd_done after B is driven; must be >= 2.
- CNT_W, $clog2(TIMEOUT+1), width of the timeout counter (derived; not overridden).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  master can accept a pair.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_gcd  out  DATA_W  GCD result.
- out_err  out  1  result is invalid (timeout); qualified by out_valid.
- gcd_start  out  1  start pulse to GCD core.
- gcd_data  out  DATA_W  drives the core's data_input.
- gcd_done  in  1  core done.
- gcd_result  in  DATA_W  core out_A (equals out_B when done).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=0 in reset, 1 in the first IDLE cycle after release.
  - out_valid=0, out_gcd=0, out_err=0, gcd_start=0, gcd_data=0, timeout counter=0.
- Core protocol (fixed):
  - The core samples start at edge N, loads A from data_input at edge N+1, and loads B at edge N+2.
  - done is a level that stays high while the core sits in its done state.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, RESP. All outputs are registered.
- IDLE:
  - in_ready=1. On in_valid&in_ready, latch a_r=in_a and b_r=in_b.
  - If a_r==0 or b_r==0: out_gcd=a_r|b_r (gcd(x,0)=x, gcd(0,0)=0), out_err=0, go to RESP. The core is not started.
  - Otherwise go to START.
- START: gcd_start=1 for exactly this one cycle; gcd_data=a_r; go to LOAD_A.
- LOAD_A: gcd_start=0; gcd_data=a_r; go to LOAD_B.
- LOAD_B: gcd_data=b_r; clear the counter; go to WAIT.
- WAIT:
  - gcd_data holds b_r.
  - If gcd_done=1: out_gcd=gcd_result, out_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: out_gcd=0, out_err=1, go to RESP.
  - Else counter+1.
  - If gcd_done and timeout occur in the same cycle, done wins.
- RESP:
  - out_valid=1; out_gcd and out_err are held stable until out_valid&out_ready.
  - On the handshake, out_valid drops on the next edge and the state returns to IDLE.
- in_ready=0 in every state except IDLE; one job is in flight at a time.
- Minimum latency from input handshake to out_valid:
  - 1 cycle for the zero short-circuit.
  - 4+D cycles for a core job, where D is the number of WAIT cycles before done is seen.
- out_valid with out_ready held high: the handshake completes in the first RESP cycle, and in_ready=1 in the following cycle.
- Mid-operation reset: all state is lost, gcd_start drops immediately, and no partial result is emitted.
- gcd_done seen in any state other than WAIT is ignored.

Decomposition:
- Shared package gcd_pkg:
  - DATA_W default.
  - State enum for this master (3 bits, matching the controller's WIDTH_STATE).
  - Core load-timing constants: START_TO_A=1, START_TO_B=2.
- One natural sub-module: gcd_timeout_ctr (clear/enable/terminal-count). Everything else stays in a single FSM plus operand/result registers.

Test Plan:
- (48,18) with an integrated core:
  - gcd_start is high exactly 1 cycle, gcd_data=48 then 48 then 18.
  - out_gcd=6, out_err=0.
  - in_ready is low from acceptance until after the output handshake.
- (0,35) -> out_valid in 1 cycle with out_gcd=35, gcd_start never asserted. (0,0) -> out_gcd=0.
- Core model that never raises done, TIMEOUT=16 -> out_valid exactly 16 WAIT cycles after LOAD_B, with out_err=1 and out_gcd=0.
- (21,14) with out_ready held low 10 cycles:
  - out_valid stays high and out_gcd=7 is stable throughout.
  - A second in_valid pair is not accepted until the output handshake.
- Back-to-back jobs (17,5), (100,75), with out_ready=1 and in_valid held -> results 1 then 25, in order, with no dropped pair.
- Reset asserted during WAIT -> all outputs 0 asynchronously; after release, a new pair (9,6) yields 3.
